// File: rtl/task3_pkg.sv
// task3_pkg: shared state encoding, sweep size and vec_idx bit positions for the task3 stimulus sequencer.
package task3_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
  localparam int NUM_VECTORS = 32;
  localparam int IDX_W = 5;
  localparam int X_BIT = 4;
  localparam int Y_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int S1_BIT = 1;
  localparam int S0_BIT = 0;
endpackage

// File: rtl/task3_stim_seq_if.sv
// task3_stim_seq_if: control, stimulus and capture signals between the sequencer (master) and its user (slave).
interface task3_stim_seq_if;
  import task3_pkg::*;
  logic start;
  logic stall;
  logic T;
  logic X;
  logic Y;
  logic Z;
  logic S0;
  logic S1;
  logic [IDX_W-1:0] vec_idx;
  logic sample;
  logic busy;
  logic done;
  logic [NUM_VECTORS-1:0] results;
  logic [5:0] ones_count;
  modport master (
    input start, stall, T,
    output X, Y, Z, S0, S1, vec_idx, sample, busy, done, results, ones_count
  );
  modport slave (
    output start, stall, T,
    input X, Y, Z, S0, S1, vec_idx, sample, busy, done, results, ones_count
  );
endinterface

// File: rtl/task3_hold_counter.sv
// task3_hold_counter: counts cycles within one hold window; last flags the final cycle of the window.
module task3_hold_counter #(
  parameter int HOLD_CYCLES = 5
) (
  input  logic clk,
  input  logic s_reset,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int W = $clog2(HOLD_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign last = cnt_q == W'(HOLD_CYCLES - 1);
  assign cnt_d = (clr | (en & last)) ? '0 : en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk)
    cnt_q <= !s_reset ? '0 : cnt_d;
endmodule

// File: rtl/task3_stim_seq.sv
// task3_stim_seq: sweeps all 32 {X,Y,Z,S1,S0} vectors with a programmable hold; T capture enabled by TASK3_CAPTURE_EN.
module task3_stim_seq
  import task3_pkg::*;
#(
  parameter int HOLD_CYCLES = 5
) (
  input logic             clk,
  input logic             s_reset,
  task3_stim_seq_if.master bus
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;
  logic [1:0] state_q, state_d;
  logic [IDX_W-1:0] vec_q, vec_d;
  logic run, go, last, sample, fin;
  assign run = state_q == RUN;
  assign go = !run & bus.start;
  assign sample = run & last & !bus.stall;
  assign fin = sample & (vec_q == IDX_W'(NUM_VECTORS - 1));
  task3_hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk    (clk),
    .s_reset(s_reset),
    .clr    (!run),
    .en     (run & !bus.stall),
    .last   (last)
  );
  always_comb begin
    state_d = go ? RUN : fin ? DONE : state_q;
    vec_d = go ? '0 : (sample & !fin) ? vec_q + IDX_W'(1) : vec_q;
  end
  always_ff @(posedge clk) begin
    if (!s_reset) begin
      state_q <= IDLE;
      vec_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
    end
  end
  assign bus.X = vec_q[X_BIT];
  assign bus.Y = vec_q[Y_BIT];
  assign bus.Z = vec_q[Z_BIT];
  assign bus.S1 = vec_q[S1_BIT];
  assign bus.S0 = vec_q[S0_BIT];
  assign bus.vec_idx = vec_q;
  assign bus.sample = sample;
  assign bus.busy = run;
  assign bus.done = state_q == DONE;
`ifdef TASK3_CAPTURE_EN
  logic [NUM_VECTORS-1:0] res_q, res_d;
  logic [5:0] ones_q, ones_d;
  always_comb begin
    res_d = go ? '0 : sample ? (res_q & ~(NUM_VECTORS'(1) << vec_q)) | (NUM_VECTORS'(bus.T) << vec_q) : res_q;
    ones_d = go ? '0 : ones_q + 6'(sample & bus.T);
  end
  always_ff @(posedge clk) begin
    if (!s_reset) begin
      res_q <= '0;
      ones_q <= '0;
    end else begin
      res_q <= res_d;
      ones_q <= ones_d;
    end
  end
  assign bus.results = res_q;
  assign bus.ones_count = ones_q;
`else
  assign bus.results = '0;
  assign bus.ones_count = '0;
`endif
endmodule
